// File: rtl/bsg_asic_iodelay_pkg.sv
// Shared state encoding and IODELAY2 constants for the IODELAY2 tap sequencer.
// The wait timeout limit is used only when BSG_ASIC_IODELAY_TAP_CTRL_TIMEOUT_EN is defined.
package bsg_asic_iodelay_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StCal,
      StCalWait,
      StRst,
      StRstWait,
      StStepChk,
      StStep,
      StStepWait,
      StDone
   } iodelay_state_e;

   localparam int unsigned IodelayTapMax       = 255;
   localparam int unsigned IodelayGuardDefault = 3;
   localparam int unsigned IodelayTimeoutMax   = 4095;

   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bsg_asic_iodelay_wait_busy.sv
// Guard delay plus BUSY wait after a CAL/RST/CE pulse; reused by every *_WAIT state.
// BSG_ASIC_IODELAY_TAP_CTRL_TIMEOUT_EN adds a 12-bit bound on the wait.
module bsg_asic_iodelay_wait_busy
   import bsg_asic_iodelay_pkg::*;
#(
   parameter int unsigned guard_cycles_p = IodelayGuardDefault
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic start_i,
   input  logic busy_i,
   output logic done_o,
   output logic timeout_o
);

   // BUSY is first sampled in the guard_cycles_p-th cycle after the pulse.
   localparam int unsigned sample_at_lp = (guard_cycles_p == 0) ? 0 : guard_cycles_p - 1;
   localparam int unsigned guard_w_lp   = clog2_min1(sample_at_lp + 1);

   logic                  active_q, active_d;
   logic [guard_w_lp-1:0] guard_q, guard_d;
   logic                  guard_met;

   assign guard_met = (guard_q == guard_w_lp'(sample_at_lp));
   assign done_o    = active_q & guard_met & ~busy_i;

`ifdef BSG_ASIC_IODELAY_TAP_CTRL_TIMEOUT_EN
   logic [11:0] tcnt_q, tcnt_d;

   assign timeout_o = active_q & ~done_o & (tcnt_q == 12'(IodelayTimeoutMax));

   always_comb begin
      tcnt_d = tcnt_q;
      if (start_i) begin
         tcnt_d = 12'd1;
      end else if (active_q && (tcnt_q != 12'(IodelayTimeoutMax))) begin
         tcnt_d = tcnt_q + 12'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         tcnt_q <= '0;
      end else begin
         tcnt_q <= tcnt_d;
      end
   end
`else
   assign timeout_o = 1'b0;
`endif

   always_comb begin
      active_d = active_q;
      guard_d  = guard_q;
      if (start_i) begin
         active_d = 1'b1;
         guard_d  = '0;
      end else if (active_q) begin
         if (done_o || timeout_o) begin
            active_d = 1'b0;
         end else if (!guard_met) begin
            guard_d = guard_q + guard_w_lp'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         active_q <= 1'b0;
         guard_q  <= '0;
      end else begin
         active_q <= active_d;
         guard_q  <= guard_d;
      end
   end

endmodule

// File: rtl/bsg_asic_iodelay_tap_ctrl.sv
// Programs IODELAY2 (VARIABLE_FROM_ZERO, ODATAIN) tap settings via CAL/RST/CE/INC, tracking taps.
// BSG_ASIC_IODELAY_TAP_CTRL_TIMEOUT_EN adds err_o and a bounded BUSY wait.
module bsg_asic_iodelay_tap_ctrl
   import bsg_asic_iodelay_pkg::*;
#(
   parameter int unsigned els_p          = 4,
   parameter int unsigned tap_width_p    = 8,
   parameter int unsigned guard_cycles_p = IodelayGuardDefault,
   localparam int unsigned id_width_lp   = clog2_min1(els_p)
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         v_i,
   input  logic [id_width_lp-1:0]       id_i,
   input  logic [tap_width_p-1:0]       tap_i,
   input  logic                         recal_i,
   output logic                         ready_o,
   output logic                         done_o,
   output logic [els_p-1:0]             cal_o,
   output logic [els_p-1:0]             rst_o,
   output logic [els_p-1:0]             ce_o,
   output logic                         inc_o,
   input  logic [els_p-1:0]             busy_i,
`ifdef BSG_ASIC_IODELAY_TAP_CTRL_TIMEOUT_EN
   output logic                         err_o,
`endif
   output logic [els_p*tap_width_p-1:0] tap_o
);

   localparam logic [tap_width_p-1:0] tap_max_lp = tap_width_p'(IodelayTapMax);
   localparam logic [tap_width_p-1:0] tap_one_lp = tap_width_p'(1);

   iodelay_state_e                      state_q, state_d;
   logic [id_width_lp-1:0]              id_q, id_d;
   logic [tap_width_p-1:0]              target_q, target_d;
   logic                                inc_q, inc_d;
   logic [els_p-1:0][tap_width_p-1:0]   taps_q, taps_d;
   logic [els_p-1:0]                    needs_cal_q, needs_cal_d;

   logic [els_p-1:0]                    sel;
   logic [tap_width_p-1:0]              cur_tap;
   logic                                id_i_valid, id_q_valid;
   logic                                wait_start, wait_done, wait_timeout;

   assign id_i_valid = (32'(id_i) < els_p);
   assign id_q_valid = (32'(id_q) < els_p);
   assign cur_tap    = taps_q[id_q];

   always_comb begin
      sel = '0;
      if (id_q_valid) begin
         sel[id_q] = 1'b1;
      end
   end

   bsg_asic_iodelay_wait_busy #(
      .guard_cycles_p(guard_cycles_p)
   ) u_wait (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .start_i  (wait_start),
      .busy_i   (busy_i[id_q]),
      .done_o   (wait_done),
      .timeout_o(wait_timeout)
   );

   always_comb begin
      state_d     = state_q;
      id_d        = id_q;
      target_d    = target_q;
      inc_d       = inc_q;
      taps_d      = taps_q;
      needs_cal_d = needs_cal_q;
      wait_start  = 1'b0;
      cal_o       = '0;
      rst_o       = '0;
      ce_o        = '0;

      unique case (state_q)
         StIdle: begin
            if (v_i) begin
               id_d     = id_i;
               target_d = tap_i;
               if (!id_i_valid) begin
                  state_d = StDone;
               end else if (recal_i || needs_cal_q[id_i]) begin
                  state_d = StCal;
               end else begin
                  state_d = StStepChk;
               end
            end
         end
         StCal: begin
            cal_o      = sel;
            wait_start = 1'b1;
            state_d    = StCalWait;
         end
         StCalWait: begin
            if (wait_done) state_d = StRst;
         end
         StRst: begin
            rst_o              = sel;
            taps_d[id_q]       = '0;
            needs_cal_d[id_q]  = 1'b0;
            wait_start         = 1'b1;
            state_d            = StRstWait;
         end
         StRstWait: begin
            if (wait_done) state_d = StStepChk;
         end
         StStepChk: begin
            if (cur_tap == target_q) begin
               state_d = StDone;
            end else begin
               inc_d   = (target_q > cur_tap);
               state_d = StStep;
            end
         end
         StStep: begin
            ce_o       = sel;
            wait_start = 1'b1;
            state_d    = StStepWait;
            // Saturating update: the tracked tap never wraps.
            if (inc_q && (cur_tap != tap_max_lp)) begin
               taps_d[id_q] = cur_tap + tap_one_lp;
            end else if (!inc_q && (cur_tap != '0)) begin
               taps_d[id_q] = cur_tap - tap_one_lp;
            end
         end
         StStepWait: begin
            if (wait_done) state_d = StStepChk;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Only asserted from a *_WAIT state; the element's tap is now unknown.
      if (wait_timeout) begin
         state_d           = StDone;
         needs_cal_d[id_q] = 1'b1;
      end
   end

`ifdef BSG_ASIC_IODELAY_TAP_CTRL_TIMEOUT_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (wait_timeout) begin
         err_d = 1'b1;
      end else if (state_q == StDone) begin
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_o = (state_q == StDone) & err_q;
`endif

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= StIdle;
         id_q        <= '0;
         target_q    <= '0;
         inc_q       <= 1'b0;
         taps_q      <= '0;
         needs_cal_q <= '1;
      end else begin
         state_q     <= state_d;
         id_q        <= id_d;
         target_q    <= target_d;
         inc_q       <= inc_d;
         taps_q      <= taps_d;
         needs_cal_q <= needs_cal_d;
      end
   end

   assign ready_o = (state_q == StIdle);
   assign done_o  = (state_q == StDone);
   assign inc_o   = inc_q;
   assign tap_o   = taps_q;

endmodule
